// File: rtl/decode_stage.sv
// RV32I decode stage: FIFO-buffered fetch side, registered decoded bundle on the execute side.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instruction,
  input  logic [XLEN-1:0]               in_pc,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [4:0]                    rs1_address,
  output logic [4:0]                    rs2_address,
  output logic [4:0]                    rd_address,
  output logic [31:0]                   imm,
  output logic [3:0]                    alu_rd_operator,
  output logic [1:0]                    alu_rd_operand1_src,
  output logic [2:0]                    alu_rd_operand2_src,
  output logic [1:0]                    alu_pc_operand1_src,
  output logic [1:0]                    next_pc_src,
  output logic                          reg_write_data_src,
  output logic                          reg_wren,
  output logic                          ram_wren,
  output logic                          illegal,
  output logic                          muldiv_valid,
  output logic [2:0]                    muldiv_op,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_IMM  = 2'd2;
  localparam logic [2:0] OP2_RS2  = 3'd0;
  localparam logic [2:0] OP2_IMM  = 3'd1;
  localparam logic [2:0] OP2_FOUR = 3'd2;
  localparam logic [1:0] PCOP_PC  = 2'd0;
  localparam logic [1:0] PCOP_RS1 = 2'd1;
  localparam logic [1:0] NPC_NOT_BRANCH    = 2'd0;
  localparam logic [1:0] NPC_ALWAYS_BRANCH = 2'd1;
  localparam logic [1:0] NPC_BRANCH_ZERO   = 2'd2;
  localparam logic [1:0] NPC_BRANCH_NZERO  = 2'd3;
  localparam logic       WD_ALU = 1'b0;
  localparam logic       WD_RAM = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic [1:0]      op1_src;
    logic [2:0]      op2_src;
    logic [1:0]      pc_op1_src;
    logic [1:0]      npc_src;
    logic            wd_src;
    logic            reg_wren;
    logic            ram_wren;
    logic            illegal;
    logic            muldiv_valid;
    logic [2:0]      muldiv_op;
  } bundle_t;

  logic [31:0]     ins_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            out_valid_q;
  bundle_t         out_q;
  bundle_t         raw, dec_d;
  logic            raw_ill;
  logic            push, pop;
  logic [31:0]     instr;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  assign in_ready = (count_q != CNT_FULL);
  assign push     = in_valid && in_ready && !flush && !rst;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);
  assign instr    = ins_mem_q[rd_ptr_q];
  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];

  // Decode the FIFO head into a complete bundle; illegal encodings collapse to a zeroed bundle.
  always_comb begin
    raw        = '0;
    raw.pc     = pc_mem_q[rd_ptr_q];
    raw.rs1    = instr[19:15];
    raw.rs2    = instr[24:20];
    raw.rd     = instr[11:7];
    raw.alu_op = ALU_ADD;
    raw_ill    = 1'b0;
    case (opcode)
      OPC_OP: begin
        raw.reg_wren = 1'b1;
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          raw.alu_op = alu_from_f3(f3, f7[5]);
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          raw.muldiv_valid = 1'b1;
          raw.muldiv_op    = f3;
        end
`endif
        else begin
          raw_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        raw.imm      = {{20{instr[31]}}, instr[31:20]};
        raw.op2_src  = OP2_IMM;
        raw.reg_wren = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
            raw.alu_op = alu_from_f3(f3, f7[5]);
          end else begin
            raw_ill = 1'b1;
          end
        end else begin
          raw.alu_op = alu_from_f3(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        raw.imm      = {{20{instr[31]}}, instr[31:20]};
        raw.op2_src  = OP2_IMM;
        raw.wd_src   = WD_RAM;
        raw.reg_wren = 1'b1;
      end
      OPC_STORE: begin
        raw.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        raw.op2_src  = OP2_IMM;
        raw.rd       = 5'd0;
        raw.ram_wren = 1'b1;
      end
      OPC_BRANCH: begin
        raw.imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        raw.rd         = 5'd0;
        raw.pc_op1_src = PCOP_PC;
        case (f3)
          3'b000: begin raw.alu_op = ALU_SUB;  raw.npc_src = NPC_BRANCH_ZERO;  end
          3'b001: begin raw.alu_op = ALU_SUB;  raw.npc_src = NPC_BRANCH_NZERO; end
          3'b100: begin raw.alu_op = ALU_SLT;  raw.npc_src = NPC_BRANCH_NZERO; end
          3'b101: begin raw.alu_op = ALU_SLT;  raw.npc_src = NPC_BRANCH_ZERO;  end
          3'b110: begin raw.alu_op = ALU_SLTU; raw.npc_src = NPC_BRANCH_NZERO; end
          3'b111: begin raw.alu_op = ALU_SLTU; raw.npc_src = NPC_BRANCH_ZERO;  end
          default: raw_ill = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        raw.imm        = (opcode == OPC_JAL)
                         ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
                         : {{20{instr[31]}}, instr[31:20]};
        raw.op1_src    = OP1_PC;
        raw.op2_src    = OP2_FOUR;
        raw.npc_src    = NPC_ALWAYS_BRANCH;
        raw.pc_op1_src = (opcode == OPC_JAL) ? PCOP_PC : PCOP_RS1;
        raw.reg_wren   = 1'b1;
      end
      OPC_LUI: begin
        raw.imm      = {instr[31:12], 12'h000};
        raw.op1_src  = OP1_IMM;
        raw.op2_src  = OP2_RS2;
        raw.rs2      = 5'd0;
        raw.reg_wren = 1'b1;
      end
      OPC_AUIPC: begin
        raw.imm      = {instr[31:12], 12'h000};
        raw.op1_src  = OP1_PC;
        raw.op2_src  = OP2_IMM;
        raw.reg_wren = 1'b1;
      end
      default: raw_ill = 1'b1;
    endcase

    if (raw_ill) begin
      dec_d         = '0;
      dec_d.pc      = raw.pc;
      dec_d.illegal = 1'b1;
    end else begin
      dec_d = raw;
    end
  end

  // Instruction buffer storage; only the write port is clocked.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem_q[wr_ptr_q] <= in_instruction;
      pc_mem_q[wr_ptr_q]  <= in_pc;
    end
  end

  // Pointers, occupancy and the output register; reset outranks flush, both outrank handshakes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid           = out_valid_q;
  assign fifo_count          = count_q;
  assign out_pc              = out_q.pc;
  assign rs1_address         = out_q.rs1;
  assign rs2_address         = out_q.rs2;
  assign rd_address          = out_q.rd;
  assign imm                 = out_q.imm;
  assign alu_rd_operator     = out_q.alu_op;
  assign alu_rd_operand1_src = out_q.op1_src;
  assign alu_rd_operand2_src = out_q.op2_src;
  assign alu_pc_operand1_src = out_q.pc_op1_src;
  assign next_pc_src         = out_q.npc_src;
  assign reg_write_data_src  = out_q.wd_src;
  assign reg_wren            = out_q.reg_wren;
  assign ram_wren            = out_q.ram_wren;
  assign illegal             = out_q.illegal;
  assign muldiv_valid        = out_q.muldiv_valid;
  assign muldiv_op           = out_q.muldiv_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued at push time and compared on handshake.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int FD   = 4;

  localparam logic [3:0] E_ADD = 4'd0;
  localparam logic [3:0] E_SUB = 4'd1;
  localparam logic [3:0] E_SRA = 4'd7;
  localparam logic [1:0] E_NOT = 2'd0;
  localparam logic [1:0] E_ALW = 2'd1;
  localparam logic [1:0] E_BZ  = 2'd2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instruction;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [4:0] rs1_address, rs2_address, rd_address;
  logic [31:0] imm;
  logic [3:0] alu_rd_operator;
  logic [1:0] alu_rd_operand1_src, alu_pc_operand1_src, next_pc_src;
  logic [2:0] alu_rd_operand2_src, muldiv_op;
  logic reg_write_data_src, reg_wren, ram_wren, illegal, muldiv_valid;
  logic [$clog2(FD):0] fifo_count;

  decode_stage #(.XLEN(XLEN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_address(rs1_address), .rs2_address(rs2_address), .rd_address(rd_address),
    .imm(imm), .alu_rd_operator(alu_rd_operator),
    .alu_rd_operand1_src(alu_rd_operand1_src), .alu_rd_operand2_src(alu_rd_operand2_src),
    .alu_pc_operand1_src(alu_pc_operand1_src), .next_pc_src(next_pc_src),
    .reg_write_data_src(reg_write_data_src), .reg_wren(reg_wren), .ram_wren(ram_wren),
    .illegal(illegal), .muldiv_valid(muldiv_valid), .muldiv_op(muldiv_op),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [1:0]  npc;
    logic        rwen;
    logic        mwen;
    logic        ill;
    logic        mdv;
    logic [2:0]  mdop;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] im, input logic [4:0] rd,
                              input logic [3:0] op, input logic [1:0] npc, input logic rwen,
                              input logic mwen, input logic ill, input logic mdv, input logic [2:0] mdop);
    exp_t e;
    e.pc = pc; e.imm = im; e.rd = rd; e.op = op; e.npc = npc;
    e.rwen = rwen; e.mwen = mwen; e.ill = ill; e.mdv = mdv; e.mdop = mdop;
    return e;
  endfunction

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_check();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL sb_unexpected: observed pc %h expected no bundle", out_pc);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_imm", imm, e.imm);
        chk("sb_rd", 32'(rd_address), 32'(e.rd));
        chk("sb_op", 32'(alu_rd_operator), 32'(e.op));
        chk("sb_npc", 32'(next_pc_src), 32'(e.npc));
        chk("sb_rwen", 32'(reg_wren), 32'(e.rwen));
        chk("sb_mwen", 32'(ram_wren), 32'(e.mwen));
        chk("sb_illegal", 32'(illegal), 32'(e.ill));
        chk("sb_mdv", 32'(muldiv_valid), 32'(e.mdv));
        chk("sb_mdop", 32'(muldiv_op), 32'(e.mdop));
      end
    end
  endtask

  // One cycle: score the bundle about to be consumed, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    chk("push_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instruction = ins; in_pc = pc;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int accepted;
    exp_t e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = 32'h0; in_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_rd", 32'(rd_address), 32'd0);
    chk("rst_op", 32'(alu_rd_operator), 32'd0);
    chk("rst_npc", 32'(next_pc_src), 32'd0);
    chk("rst_rwen", 32'(reg_wren), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_mdv", 32'(muldiv_valid), 32'd0);

    // addi x1,x0,-1 and latency
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h100, mk(32'h100, 32'hFFFF_FFFF, 5'd1, E_ADD, E_NOT, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    chk("lat_edge1_count", 32'(fifo_count), 32'd1);
    tick();
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    tick();

    // beq x0,x0,-4
    push(32'hFE000EE3, 32'h104, mk(32'h104, 32'hFFFF_FFFC, 5'd0, E_SUB, E_BZ, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    tick(); tick();

    // Fill to capacity with out_ready low
    out_ready = 1'b0; k = 1; accepted = 0;
    for (int c = 0; c < 8; c++) begin
      logic acc;
      in_valid = 1'b1; in_instruction = addi_k(k); in_pc = 32'h200 + 32'(4 * (k - 1));
      acc = in_ready;
      if (acc) begin
        sb.push_back(mk(in_pc, 32'(k), 5'(k), E_ADD, E_NOT, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        accepted++;
      end
      tick();
      if (acc) k++;
      if (c >= 2) chk("hold_first_pc", out_pc, 32'h200);
    end
    in_valid = 1'b0;
    chk("full_accepted", 32'(accepted), 32'd5);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_hold_imm", imm, 32'd1);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instruction = addi_k(10 + i); in_pc = 32'h300 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_flush_count", 32'(fifo_count), 32'd3);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_instruction = 32'h00700393; in_pc = 32'h3F0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_imm", imm, 32'd0);
    chk("flush_out_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Illegal, jal, sub, srai, bad shift, lui, mul back to back
    push(32'h00000000, 32'h400, mk(32'h400, 32'd0, 5'd0, 4'd0, E_NOT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
    push(32'h008000EF, 32'h404, mk(32'h404, 32'd8, 5'd1, E_ADD, E_ALW, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    push(32'h40208133, 32'h408, mk(32'h408, 32'd0, 5'd2, E_SUB, E_NOT, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    push(32'h4030D093, 32'h40C, mk(32'h40C, 32'h403, 5'd1, E_SRA, E_NOT, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    push(32'h2030D093, 32'h410, mk(32'h410, 32'd0, 5'd0, 4'd0, E_NOT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
    push(32'h123452B7, 32'h414, mk(32'h414, 32'h1234_5000, 5'd5, E_ADD, E_NOT, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
`ifdef DECODE_RV32M_EN
    e = mk(32'h418, 32'd0, 5'd3, E_ADD, E_NOT, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
`else
    e = mk(32'h418, 32'd0, 5'd0, 4'd0, E_NOT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
`endif
    push(32'h022081B3, 32'h418, e);
    repeat (3) tick();

    // Reset mid-stream, asserted together with flush
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instruction = addi_k(20 + i); in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction-decode stage that replaces the single-cycle combinational decoder between fetch and execute. It buffers fetched instructions in a parametrised FIFO and decodes the FIFO head into a registered output bundle. Both sides use valid/ready handshakes. It forms fully sign-extended immediates, flags illegal encodings, and supports a pipeline flush.

## Interface
- `XLEN`, 32: PC width.
- `FIFO_DEPTH`, 4: instruction buffer entries; must be a power of 2 and ≥2.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents `in_instruction`/`in_pc`.
- `in_ready` out 1: FIFO not full.
- `in_instruction` in 32: raw instruction.
- `in_pc` in XLEN: PC of instruction.
- `flush` in 1: discard all buffered and output-held instructions.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts bundle.
- `out_pc` out XLEN: PC of decoded instruction.
- `rs1_address`, `rs2_address`, `rd_address` out 5 each: register fields.
- `imm` out 32: sign-extended immediate.
- `alu_rd_operator` out 4; `alu_rd_operand1_src` out 2; `alu_rd_operand2_src` out 3; `alu_pc_operand1_src` out 2; `next_pc_src` out 2: control fields, shared `define.v` encodings.
- `reg_write_data_src`, `reg_wren`, `ram_wren` out 1 each: writeback/store controls.
- `illegal` out 1: decoded instruction is unsupported.
- `muldiv_valid` out 1; `muldiv_op` out 3: M-extension op (see Configuration).
- `fifo_count` out $clog2(FIFO_DEPTH)+1: buffered entries, excluding the output register.

## Operation
- Push: `in_valid && in_ready` writes {pc, instruction} at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Pop/load: the output register loads the decoded FIFO head when the FIFO is non-empty and (`!out_valid || out_ready`). Otherwise the output register holds all fields stable.
- Simultaneous push and pop on a full FIFO is not allowed, because `in_ready` is 0 whenever the FIFO is full.
- Simultaneous push and pop on a non-full FIFO leaves `fifo_count` unchanged.
- Immediates:
  - I-type: sext(instr[31:20]).
  - S-type: sext({instr[31:25], instr[11:7]}).
  - B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type: {instr[31:12], 12'b0}.
  - J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R-type: 0.
- Per-opcode controls:
  - OP / OP-IMM: operator from funct3, with funct7 selecting ADD/SUB and SRL/SRA.
  - LOAD / STORE: ADD with rs1 + IMM.
  - BRANCH: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU. `next_pc_src` is branch-on-zero or branch-on-not-zero; `alu_pc_operand1_src` is PC.
  - JAL: PC + 4, always-branch, PC-relative.
  - JALR: PC + 4, always-branch, rs1-relative.
  - LUI: IMM + RS2 with `rs2_address` forced to 0.
  - AUIPC: PC + IMM.
- Illegal cases: unknown opcode; unknown funct3 in BRANCH; funct7 ∉ {0000000, 0100000} in OP; funct7 ≠ 0100000/0000000 for OP-IMM shifts. Each sets `illegal=1`, `reg_wren=0`, `ram_wren=0`, `next_pc_src`=ALWAYS_NOT_BRANCH, all other fields 0. The bundle still flows through the handshake.
- All fields are assigned on every decode; there are no held-over values from previous instructions.

## Timing
- Reset:
  - FIFO empty, `fifo_count=0`, `in_ready=1`.
  - `out_valid=0`; every decoded output is 0 (`out_pc`, addresses, `imm`, controls, `illegal`, `muldiv_*`).
- Latency: an instruction pushed at edge N into an empty stage has `out_valid=1` after edge N+1.
- Sustained throughput: 1 instruction/cycle with `out_ready=1`.
- Capacity: FIFO_DEPTH + 1 instructions, counting the output register.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- `flush` at edge N:
  - After edge N: FIFO empty and `out_valid=0`.
  - A push in the same cycle is dropped.
  - Decoded fields are zeroed.
- `rst` has priority over `flush`, and both override push/pop. Reset mid-stream discards all contents.
- `out_valid` stays high, with all fields stable, until `out_ready` is sampled high.

## Configuration
- `DECODE_RV32M_EN` defined:
  - OP with funct7=0000001 decodes as M-extension: `muldiv_valid=1`, `muldiv_op=funct3`, `reg_wren=1`, `reg_write_data_src`=ALU, `alu_rd_operator`=ADD, `illegal=0`.
- Undefined:
  - `muldiv_valid` and `muldiv_op` are tied 0.
  - funct7=0000001 in OP sets `illegal=1`.

## Test plan
- Reset, then push 0xFFF00093 (addi x1,x0,-1) with `out_ready=1` -> after 2 edges: `out_valid=1`, `imm`=0xFFFFFFFF, `rd_address`=1, operator ADD, `reg_wren=1`.
- Push 0xFE000EE3 (beq x0,x0,-4) -> `imm`=0xFFFFFFFC, operator SUB, `next_pc_src`=branch-on-zero, `reg_wren=0`.
- Hold `out_ready=0` and push continuously (FIFO_DEPTH=4) -> exactly 5 accepted, `in_ready=0`, `fifo_count=4`; the first bundle stays stable; raise `out_ready` -> 5 bundles emerge in order at 1 per cycle.
- With 3 buffered and `out_valid=1`, assert `flush` together with `in_valid` -> next cycle `fifo_count=0`, `out_valid=0`, `in_ready=1`, and the pushed instruction never appears.
- Push 0x00000000 -> `illegal=1`, `reg_wren=0`, `ram_wren=0`; then push 0x008000EF (jal x1,8) -> `imm`=8, always-branch, `illegal=0`.
- Push 0x022081B3 (mul x3,x1,x2) -> with `DECODE_RV32M_EN`: `muldiv_valid=1`, `muldiv_op=0`, `rd_address=3`; without it: `illegal=1`, `muldiv_valid=0`.
